display_scan: RTL
=================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The block SHALL have parameter DIV, default 4, giving clock cycles per digit slot; legal range is DIV >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: scan enable; 0 blanks the display.
REQ-005 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures data.
REQ-006 The block SHALL have port data, input, 32 bits: eight hex nibbles; nibble i drives digit i, digit 0 being least significant.
REQ-007 The block SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-008 The block SHALL have port an, output, 8 bits: active-low digit enables; an[i] selects digit i.
REQ-009 The block SHALL have port seg, output, 8 bits: active-low segments; seg[0..6] = a..g, seg[7] = dp.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-011 The block SHALL have port updated, output, 1 bit: one-cycle pulse when pending data is committed to display.

Function
REQ-012 The block SHALL keep a prescaler cnt that counts 0..DIV-1 and wraps; tick = (cnt == DIV-1) && en.
REQ-013 The block SHALL advance digit index idx (3 bits) on tick, wrapping 7->0, giving a frame of 8*DIV cycles.
REQ-014 The block SHALL define the frame boundary as the cycle with tick && idx == 7; frame_done SHALL be registered high for exactly the following cycle.
REQ-015 The block SHALL store data in pend and set pend_valid on load; if several loads occur before a commit, the last one wins.
REQ-016 With en=1, the block SHALL commit at a frame boundary edge when pend_valid=1: shadow <= pend, pend_valid cleared, updated high for the next cycle.
REQ-017 When load coincides with a commit edge, the block SHALL commit the old pend and capture the new data into pend with pend_valid kept at 1.
REQ-018 With en=0, the block SHALL hold cnt and idx at 0, and a pending value SHALL commit on the next edge, with updated pulsed as in REQ-016.
REQ-019 The block SHALL register an and seg every cycle from the current idx and shadow, so outputs lag idx by one cycle.
REQ-020 With en=1, the block SHALL drive an = ~(1<<idx); with en=0, an = 8'hFF and seg = 8'hFF.
REQ-021 The block SHALL decode hex to active-low segments with seg[7]=1 (dp off); required codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.
REQ-022 The block SHALL blank digit i (seg=8'hFF, an unchanged) when blank_lz=1, i>0, and nibbles i..7 of shadow are all zero; digit 0 is never blanked.
REQ-023 The block SHALL leave shadow unchanged between commits; the display never shows a partially updated value.

Reset
REQ-024 The block SHALL, while rst_n=0, immediately force cnt=0, idx=0, pend=0, pend_valid=0, shadow=0, an=8'hFF, seg=8'hFF, frame_done=0, updated=0.
REQ-025 The block SHALL, when reset is asserted mid-frame, discard any pending load, and scanning SHALL restart at digit 0 on the first edge after release.

Verification
REQ-026 The bench SHALL check reset and startup: DIV=4, en=1, rst_n released with no load -> an=FE, seg=C0 from the second cycle; an=FD after 4 further cycles; frame_done high once every 32 cycles.
REQ-027 The bench SHALL check a single load: load data=32'h000000A1 at cycle 3 with blank_lz=1 -> updated pulse after the first frame boundary; then digit0 seg=F9, digit1 seg=88, digits 2-7 seg=FF with an still scanning.
REQ-028 The bench SHALL check last-wins: loads of 32'h11111111 then 32'h22222222 within one frame -> exactly one updated pulse; all digits show A4.
REQ-029 The bench SHALL check load at the boundary: data 32'h3 is pending, and 32'h4 is loaded on the boundary edge -> the frame after shows B0 on digit 0, and the next frame shows 99 with a second updated pulse.
REQ-030 The bench SHALL check disabled operation: en=0, load 32'hFFFFFFFF -> an=FF, seg=FF, updated pulse one edge later; after en=1, every digit shows 8E.
REQ-031 The bench SHALL check reset mid-frame: rst_n pulled low at idx=5 with a load pending -> an/seg=FF immediately; after release, digit 0 shows C0 and no updated pulse occurs.

Source files
------------

// File: rtl/display_scan.sv
// Eight-digit multiplexed hex display scanner with double-buffered data and leading-zero blanking.
// an/seg are registered one cycle behind the digit index; loads commit at frame boundaries (at once while disabled).
module display_scan #(
   parameter int DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] data,
   input  logic        blank_lz,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        frame_done,
   output logic        updated
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [31:0]   r_pend;
   logic          r_pend_valid;
   logic [31:0]   r_shadow;
   logic [7:0]    r_an;
   logic [7:0]    r_seg;
   logic          r_frame_done;
   logic          r_updated;

   logic          w_last;
   logic          w_tick;
   logic          w_boundary;
   logic          w_commit;
   logic [3:0]    w_nibble;
   logic          w_upper_zero;
   logic          w_blank;
   logic [7:0]    w_an;
   logic [7:0]    w_seg;

   function automatic logic [7:0] hex7(input logic [3:0] h);
      logic [7:0] s;
      case (h)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign w_last     = (r_cnt == CW'(DIV - 1));
   assign w_tick     = w_last && en;
   assign w_boundary = w_tick && (r_idx == 3'd7);
   // While disabled there is no scan to tear, so a pending value commits immediately.
   assign w_commit   = r_pend_valid && (en ? w_boundary : 1'b1);

   assign w_nibble     = r_shadow[{r_idx, 2'b00} +: 4];
   assign w_upper_zero = ((r_shadow >> {r_idx, 2'b00}) == 32'd0);
   assign w_blank      = blank_lz && (r_idx != 3'd0) && w_upper_zero;

   always_comb begin
      w_an  = 8'hFF;
      w_seg = 8'hFF;
      if (en) begin
         w_an = ~(8'b1 << r_idx);
         if (!w_blank) begin
            w_seg = hex7(w_nibble);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= 3'd0;
      end else if (!en) begin
         r_cnt <= '0;
         r_idx <= 3'd0;
      end else if (w_last) begin
         r_cnt <= '0;
         r_idx <= r_idx + 3'd1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend       <= 32'd0;
         r_pend_valid <= 1'b0;
         r_shadow     <= 32'd0;
      end else begin
         if (w_commit) begin
            r_shadow <= r_pend;
         end
         // A load on the commit edge wins over the clear, so the new value stays pending.
         if (load) begin
            r_pend       <= data;
            r_pend_valid <= 1'b1;
         end else if (w_commit) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an         <= 8'hFF;
         r_seg        <= 8'hFF;
         r_frame_done <= 1'b0;
         r_updated    <= 1'b0;
      end else begin
         r_an         <= w_an;
         r_seg        <= w_seg;
         r_frame_done <= w_boundary;
         r_updated    <= w_commit;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign frame_done = r_frame_done;
   assign updated    = r_updated;

endmodule
